// File: rtl/jam_cost_arbiter.sv
// Purpose : shares one cost-ROM read port (W,J -> Cost) among NUM_REQ engines, with round-robin grants and burst locking.
// Latency : grant is combinational (0 cycles); the response strobe follows the accepted beat by 2 edges.
// Backpr. : req is held until gnt; a locked owner blocks all others until release, even while its own req is low.
// Ports   : CLK/RST (async, active-high); req/req_last/req_w/req_j per engine; gnt one-hot;
//           W/J registered ROM address; Cost ROM data in; rsp_valid/rsp_cost registered response; locked.
module jam_cost_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [3*NUM_REQ-1:0]   req_w,
  input  logic [3*NUM_REQ-1:0]   req_j,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [2:0]             W,
  output logic [2:0]             J,
  input  logic [6:0]             Cost,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [6:0]             rsp_cost,
  output logic                   locked
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]         mode;
  logic [2:0]         owner;
  logic [2:0]         ptr;
  logic [3:0]         beat_cnt;
  // Tag stage 1 rides alongside W/J; rsp_valid itself is the second tag stage.
  logic               s1_vld;
  logic [2:0]         s1_idx;

  logic [2:0]         sel_idx;
  logic               sel_vld;
  logic               sel_last;
  logic [2:0]         sel_w;
  logic [2:0]         sel_j;
  logic [3:0]         scan_sum;
  logic [2:0]         scan_idx;
  logic [2:0]         nxt_ptr;
  logic               acc;
  logic [NUM_REQ-1:0] s1_oh;

  // Pick the requester. In IDLE, scan offsets from the highest down to 0 so the
  // last hit written is the one nearest ptr (the round-robin winner).
  always_comb begin
    sel_idx  = '0;
    sel_vld  = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    if (mode == S_BURST) begin
      sel_idx = owner;
      for (int i = 0; i < NUM_REQ; i++)
        if (3'(i) == owner) sel_vld = req[i];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        scan_sum = {1'b0, ptr} + 4'(k);
        scan_idx = (scan_sum >= 4'(NUM_REQ)) ? 3'(scan_sum - 4'(NUM_REQ)) : 3'(scan_sum);
        for (int i = 0; i < NUM_REQ; i++)
          if (3'(i) == scan_idx && req[i]) begin
            sel_idx = 3'(i);
            sel_vld = 1'b1;
          end
      end
    end
  end

  assign acc = sel_vld & ~RST;

  always_comb begin
    gnt      = '0;
    sel_last = 1'b0;
    sel_w    = '0;
    sel_j    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (3'(i) == sel_idx) begin
        gnt[i]   = acc;
        sel_last = req_last[i];
        sel_w    = req_w[3*i +: 3];
        sel_j    = req_j[3*i +: 3];
      end
  end

  assign nxt_ptr = (sel_idx == 3'(NUM_REQ - 1)) ? 3'd0 : sel_idx + 3'd1;

  always_comb begin
    s1_oh = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (3'(i) == s1_idx) s1_oh[i] = s1_vld;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode      <= S_IDLE;
      owner     <= '0;
      ptr       <= '0;
      beat_cnt  <= '0;
      s1_vld    <= 1'b0;
      s1_idx    <= '0;
      W         <= '0;
      J         <= '0;
      rsp_valid <= '0;
      rsp_cost  <= '0;
      locked    <= 1'b0;
    end else begin
      s1_vld    <= acc;
      rsp_valid <= s1_oh;
      if (s1_vld) rsp_cost <= Cost;
      if (acc) begin
        s1_idx <= sel_idx;
        W      <= sel_w;
        J      <= sel_j;
        case (mode)
          S_IDLE: begin
            if (sel_last) begin
              ptr <= nxt_ptr;
            end else begin
              mode     <= S_BURST;
              owner    <= sel_idx;
              beat_cnt <= 4'd1;
              locked   <= 1'b1;
            end
          end
          S_BURST: begin
            // Forced release at MAX_BURST beats is silent; the engine simply re-arbitrates.
            if (sel_last || beat_cnt == 4'(MAX_BURST - 1)) begin
              mode   <= S_IDLE;
              ptr    <= nxt_ptr;
              locked <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
          default: mode <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Purpose : self-checking bench for jam_cost_arbiter with a cost-ROM model and a response scoreboard.
// Latency : responses are expected exactly 2 edges after each accepted beat.
// Backpr. : stimulus holds req per cycle; grants are checked against directed expectations.
module tb_jam_cost_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  req_last = '0;
  logic [11:0] req_w;
  logic [11:0] req_j;
  logic [3:0]  gnt;
  logic [2:0]  W, J;
  logic [6:0]  Cost;
  logic [3:0]  rsp_valid;
  logic [6:0]  rsp_cost;
  logic        locked;

  logic [2:0]  w [4];
  logic [2:0]  j [4];

  assign req_w = {w[3], w[2], w[1], w[0]};
  assign req_j = {j[3], j[2], j[1], j[0]};

  function automatic logic [6:0] rom(input logic [2:0] a, input logic [2:0] b);
    return 7'(9 * a + 3 * b);
  endfunction

  assign Cost = rom(W, J);

  jam_cost_arbiter #(.NUM_REQ(4), .MAX_BURST(8)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_last(req_last),
    .req_w(req_w), .req_j(req_j), .gnt(gnt), .W(W), .J(J), .Cost(Cost),
    .rsp_valid(rsp_valid), .rsp_cost(rsp_cost), .locked(locked)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int         due;
    logic [3:0] oh;
    logic [6:0] cost;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [2:0] ew = '0;
  logic [2:0] ej = '0;

  always @(posedge CLK) cyc++;

  // Scoreboard: every accepted beat must produce exactly one response 2 edges later.
  always @(negedge CLK) begin
    if (RST) begin
      sb.delete();
      ew = '0;
      ej = '0;
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e.oh));
        chk("rsp_cost", 32'(rsp_cost), 32'(e.cost));
      end else begin
        chk("rsp_idle", 32'(rsp_valid), 32'd0);
      end
      chk("W", 32'(W), 32'(ew));
      chk("J", 32'(J), 32'(ej));
      for (int i = 0; i < 4; i++)
        if (req[i] && gnt[i]) begin
          e.due  = cyc + 2;
          e.oh   = 4'(1 << i);
          e.cost = rom(w[i], j[i]);
          sb.push_back(e);
          ew = w[i];
          ej = j[i];
        end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  // Called at posedge+1: drive one cycle, check gnt/locked at negedge, return at next posedge+1.
  task automatic apply(input logic [3:0] r, input logic [3:0] l, input int w1,
                       input logic [3:0] eg, input logic el, input string tag);
    for (int i = 0; i < 4; i++) begin
      w[i] = 3'($urandom_range(0, 7));
      j[i] = 3'($urandom_range(0, 7));
    end
    if (w1 >= 0) w[1] = 3'(w1);
    req      = r;
    req_last = l;
    @(negedge CLK);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".locked"}, 32'(locked), 32'(el));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    req      = 4'b1111;
    req_last = 4'b1111;
    @(negedge CLK);
    chk("rst.gnt", 32'(gnt), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      w[i] = '0;
      j[i] = '0;
    end
    @(posedge CLK);
    #1;
    req = 4'b1111;
    @(negedge CLK);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.W", 32'(W), 32'd0);
    chk("rst.J", 32'(J), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_cost", 32'(rsp_cost), 32'd0);
    chk("rst.locked", 32'(locked), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Single beat from engine 2: W=3,J=5 -> cost 42.
    req = 4'b0100; req_last = 4'b0100; w[2] = 3'd3; j[2] = 3'd5;
    @(negedge CLK);
    chk("single.gnt", 32'(gnt), 32'b0100);
    @(posedge CLK); #1;
    req = '0; req_last = '0;
    @(negedge CLK);
    chk("single.W", 32'(W), 32'd3);
    chk("single.J", 32'(J), 32'd5);
    @(negedge CLK);
    chk("single.rsp_valid", 32'(rsp_valid), 32'b0100);
    chk("single.rsp_cost", 32'(rsp_cost), 32'd42);
    @(posedge CLK); #1;
    // ptr is now 3: with everyone requesting, engine 3 wins.
    apply(4'b1111, 4'b1111, -1, 4'b1000, 1'b0, "ptr3");
    apply(4'b0000, 4'b0000, -1, 4'b0000, 1'b0, "idle");

    // Round robin from reset.
    do_reset();
    apply(4'b1111, 4'b1111, -1, 4'b0001, 1'b0, "rr0");
    apply(4'b1111, 4'b1111, -1, 4'b0010, 1'b0, "rr1");
    apply(4'b1111, 4'b1111, -1, 4'b0100, 1'b0, "rr2");
    apply(4'b1111, 4'b1111, -1, 4'b1000, 1'b0, "rr3");
    apply(4'b1111, 4'b1111, -1, 4'b0001, 1'b0, "rr4");
    apply(4'b1111, 4'b1111, -1, 4'b0010, 1'b0, "rr5");
    for (int k = 0; k < 3; k++) apply(4'b0000, 4'b0000, -1, 4'b0000, 1'b0, "drain");

    // Burst lock: reset, engine 0 single beat (ptr -> 1), then engine 1 bursts 8 beats.
    do_reset();
    apply(4'b0001, 4'b0001, -1, 4'b0001, 1'b0, "pre");
    for (int k = 0; k < 8; k++)
      apply(4'b0011, (k == 7) ? 4'b0011 : 4'b0001, k, 4'b0010, (k != 0), "burst");
    apply(4'b0001, 4'b0001, -1, 4'b0001, 1'b0, "after_burst");

    // Forced release: ptr=1, engine 3 wins and never sends last.
    for (int k = 0; k < 8; k++)
      apply(4'b1001, 4'b0001, -1, 4'b1000, (k != 0), "forced");
    apply(4'b1001, 4'b0001, -1, 4'b0001, 1'b0, "forced_next");
    apply(4'b1000, 4'b0000, -1, 4'b1000, 1'b0, "rearb");
    apply(4'b1000, 4'b1000, -1, 4'b1000, 1'b1, "rearb_last");
    apply(4'b0000, 4'b0000, -1, 4'b0000, 1'b0, "idle2");

    // Owner gap: engine 2 locks, drops req for 3 cycles, then finishes.
    apply(4'b0100, 4'b0000, -1, 4'b0100, 1'b0, "gap_lock");
    for (int k = 0; k < 3; k++) apply(4'b0010, 4'b0010, -1, 4'b0000, 1'b1, "gap");
    apply(4'b0110, 4'b0110, -1, 4'b0100, 1'b1, "gap_resume");
    apply(4'b0010, 4'b0010, -1, 4'b0010, 1'b0, "gap_next");
    apply(4'b0000, 4'b0000, -1, 4'b0000, 1'b0, "idle3");

    // Reset mid-burst: engine 0 bursts (ptr=2 -> wraps to 0), reset hits on beat 4.
    for (int k = 0; k < 3; k++) apply(4'b0001, 4'b0000, -1, 4'b0001, (k != 0), "pre_rst");
    req = 4'b0001; req_last = 4'b0000;
    #1;
    chk("midrst.gnt_before", 32'(gnt), 32'b0001);
    RST = 1'b1;
    #1;
    chk("midrst.gnt", 32'(gnt), 32'd0);
    chk("midrst.W", 32'(W), 32'd0);
    chk("midrst.J", 32'(J), 32'd0);
    chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst.rsp_cost", 32'(rsp_cost), 32'd0);
    chk("midrst.locked", 32'(locked), 32'd0);
    @(posedge CLK); #1;
    do_reset();
    apply(4'b0110, 4'b0110, -1, 4'b0010, 1'b0, "post_rst");
    apply(4'b0110, 4'b0110, -1, 4'b0100, 1'b0, "post_rst2");
    for (int k = 0; k < 4; k++) apply(4'b0000, 4'b0000, -1, 4'b0000, 1'b0, "drain2");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/jam_cost_arbiter.md
# jam_cost_arbiter

Shares the single cost-ROM read port (W, J -> Cost) among NUM_REQ permutation-evaluation engines so that several job-assignment searches can run in parallel. Each engine issues (worker, job) lookups through a request/grant handshake and may lock the port for a burst, normally the 8 lookups of one permutation. Grants rotate round-robin between bursts. Returned costs are registered and routed back to the owning engine.

## Interface
- NUM_REQ, 4: number of requesting engines (2..8).
- MAX_BURST, 8: maximum beats per locked burst before forced release (2..16).
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-engine lookup request, held until granted.
- req_last  in  NUM_REQ  marks the final beat of a burst.
- req_w  in  3*NUM_REQ  worker index; engine i uses bits [3i+2:3i].
- req_j  in  3*NUM_REQ  job index; engine i uses bits [3i+2:3i].
- gnt  out  NUM_REQ  combinational one-hot grant; req[i]&gnt[i] = beat accepted.
- W  out  3  registered worker index to cost ROM.
- J  out  3  registered job index to cost ROM.
- Cost  in  7  cost ROM data, combinational from W/J.
- rsp_valid  out  NUM_REQ  registered one-hot response strobe.
- rsp_cost  out  7  registered cost for the engine flagged by rsp_valid.
- locked  out  1  registered; high while a burst owns the port.

## Operation
- Registered state: mode {IDLE, BURST}, owner (3b), ptr (3b, round-robin start), beat_cnt (4b), two-stage tag pipeline (valid + index).
- IDLE: gnt = first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ. No req means gnt=0.
- On an accepted beat in IDLE:
  - req_last=1: stay IDLE; ptr <= i+1 mod NUM_REQ.
  - req_last=0: go to BURST; owner <= i; beat_cnt <= 1; locked <= 1.
- BURST: gnt[owner] = req[owner]; all other grants are 0. An owner that drops req keeps the lock, and the port idles.
- On an accepted beat in BURST:
  - Release when req_last=1 or beat_cnt == MAX_BURST-1. Release means: go to IDLE, ptr <= owner+1 mod NUM_REQ, locked <= 0.
  - Otherwise beat_cnt increments.
- Forced release does not notify the engine. The engine's next beat re-arbitrates as a fresh request.
- Datapath for a beat accepted in cycle T:
  - W/J <= req_w/req_j of i at edge T. The tag records i.
  - In cycle T+1, Cost is valid from the ROM.
  - rsp_cost <= Cost and rsp_valid <= onehot(i) at edge T+1.
- W/J hold their last value when no beat is accepted. rsp_valid is 0 on those cycles.
- Requester indices >= NUM_REQ do not exist. ptr wraps from NUM_REQ-1 to 0.

## Timing
- Reset (asynchronous): mode=IDLE, ptr=0, owner=0, beat_cnt=0, W=0, J=0, rsp_valid=0, rsp_cost=0, locked=0, tag pipeline invalid. gnt is forced to 0 while RST=1.
- Reset mid-burst aborts the burst. In-flight responses are discarded and never asserted.
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when the port is free.
- Accept-to-response latency: 2 edges. Throughput: 1 beat per cycle, including back-to-back beats from different engines in IDLE.
- The release beat and a new grant cannot coincide. The next owner is granted no earlier than the cycle after the release edge.
- A response stays in flight across a release and is delivered to its original engine.

## Test plan
- Single beat: req[2]=1, req_last[2]=1, w=3, j=5, ROM cost(3,5)=42 -> gnt=0100 in the same cycle; W=3, J=5 after edge 1; rsp_valid=0100 and rsp_cost=42 after edge 2; ptr=3.
- Round robin: all four engines request single beats continuously from reset -> grant order 0,1,2,3,0,1; rsp_valid follows the same order two cycles later.
- Burst lock: engine 1 sends 8 beats (w=0..7, last on beat 8) while engine 0 also requests -> gnt stays at 1 for 8 beats; locked=1 from edge 1 through edge 8; engine 0 is granted the cycle after.
- Forced release: MAX_BURST=8, engine 3 never asserts last -> release after the 8th beat; engine 0's pending request is granted next; engine 3 re-arbitrates afterwards.
- Owner gap: engine 2 locks, then drops req for 3 cycles while engine 1 requests -> gnt=0 for those 3 cycles and locked stays 1; engine 2 resumes and is granted.
- Reset mid-burst: assert RST at beat 4 with two responses in flight -> all outputs go to 0 immediately; no rsp_valid appears afterwards; the first grant after reset goes to the lowest requesting index.
